// File: rtl/lif_neuron_if.sv
// Weight-write bus, timestep trigger and status/result signals of one LIF neuron.
// The master side (core array or bench) drives stimulus; the neuron is the slave.
interface lif_neuron_if #(
    parameter int WIDTH     = 32,
    parameter int WEIGHT_W  = 16,
    parameter int NUM_AXONS = 16,
    parameter int AW        = $clog2(NUM_AXONS)
);
    logic                       w_we;
    logic [AW-1:0]              w_addr;
    logic signed [WEIGHT_W-1:0] w_data;
    logic                       tick;
    logic [NUM_AXONS-1:0]       axon_spikes;
    logic                       busy;
    logic                       done;
    logic                       spike_out;
    logic signed [WIDTH-1:0]    potential;

    modport master (
        output w_we, w_addr, w_data, tick, axon_spikes,
        input  busy, done, spike_out, potential
    );

    modport slave (
        input  w_we, w_addr, w_data, tick, axon_spikes,
        output busy, done, spike_out, potential
    );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: serial weighted integration of spiking axons,
// leak, threshold fire with refractory period and zero/subtract post-fire reset.
module lif_neuron #(
    parameter int WIDTH     = 32,
    parameter int WEIGHT_W  = 16,
    parameter int NUM_AXONS = 16,
    parameter int REFRACT_W = 4,
    parameter int AW        = $clog2(NUM_AXONS)
) (
    input  logic                    clk,
    input  logic                    rst,
    lif_neuron_if.slave             nif,
    input  logic signed [WIDTH-1:0] cfg_threshold,
    input  logic signed [WIDTH-1:0] cfg_leak,
    input  logic                    cfg_reset_mode,
    input  logic [REFRACT_W-1:0]    cfg_refract
);

    typedef enum logic [2:0] {
        IDLE,
        INTEGRATE,
        LEAK,
        FIRE,
        REFRACT
    } state_t;

    localparam logic signed [WIDTH-1:0] POT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] POT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                     state_reg;
    logic [AW-1:0]              index_reg;
    logic [NUM_AXONS-1:0]       spikes_reg;
    logic signed [WIDTH-1:0]    threshold_reg;
    logic signed [WIDTH-1:0]    leak_reg;
    logic                       reset_mode_reg;
    logic [REFRACT_W-1:0]       refract_cfg_reg;
    logic [REFRACT_W-1:0]       refract_cnt_reg;
    logic signed [WIDTH-1:0]    potential_reg;
    logic                       busy_reg;
    logic                       done_reg;
    logic                       spike_reg;

    logic [NUM_AXONS-1:0][WEIGHT_W-1:0] weight_flat;
    logic                       weight_we;
    logic signed [WIDTH-1:0]    weight_ext;

    function automatic logic signed [WIDTH-1:0] sat_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [WIDTH:0] sum;
        sum = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        if (sum[WIDTH] != sum[WIDTH-1])
            return sum[WIDTH] ? POT_MIN : POT_MAX;
        return sum[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_sub(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [WIDTH:0] diff;
        diff = (WIDTH+1)'(a) - (WIDTH+1)'(b);
        if (diff[WIDTH] != diff[WIDTH-1])
            return diff[WIDTH] ? POT_MIN : POT_MAX;
        return diff[WIDTH-1:0];
    endfunction

    // Weights are only writable between timesteps so an in-flight sum never sees a torn table.
    assign weight_we = (state_reg == IDLE) && nif.w_we && (32'(nif.w_addr) < NUM_AXONS);

    generate
        for (genvar gi = 0; gi < NUM_AXONS; gi++) begin : g_weight
            logic [WEIGHT_W-1:0] weight_reg;

            always_ff @(posedge clk) begin
                if (!rst)
                    weight_reg <= '0;
                else if (weight_we && nif.w_addr == AW'(gi))
                    weight_reg <= nif.w_data;
            end

            assign weight_flat[gi] = weight_reg;
        end
    endgenerate

    assign weight_ext = WIDTH'($signed(weight_flat[index_reg]));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= IDLE;
            index_reg       <= '0;
            spikes_reg      <= '0;
            threshold_reg   <= '0;
            leak_reg        <= '0;
            reset_mode_reg  <= 1'b0;
            refract_cfg_reg <= '0;
            refract_cnt_reg <= '0;
            potential_reg   <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            spike_reg       <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            spike_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (nif.tick) begin
                        spikes_reg      <= nif.axon_spikes;
                        threshold_reg   <= cfg_threshold;
                        leak_reg        <= cfg_leak;
                        reset_mode_reg  <= cfg_reset_mode;
                        refract_cfg_reg <= cfg_refract;
                        index_reg       <= '0;
                        busy_reg        <= 1'b1;
                        state_reg       <= (refract_cnt_reg != '0) ? REFRACT : INTEGRATE;
                    end
                end
                INTEGRATE: begin
                    if (spikes_reg[index_reg])
                        potential_reg <= sat_add(potential_reg, weight_ext);
                    if (index_reg == AW'(NUM_AXONS - 1))
                        state_reg <= LEAK;
                    else
                        index_reg <= index_reg + AW'(1);
                end
                LEAK: begin
                    potential_reg <= sat_sub(potential_reg, leak_reg);
                    state_reg     <= FIRE;
                end
                FIRE: begin
                    if (potential_reg >= threshold_reg) begin
                        spike_reg       <= 1'b1;
                        refract_cnt_reg <= refract_cfg_reg;
                        potential_reg   <= reset_mode_reg ? sat_sub(potential_reg, threshold_reg) : '0;
                    end
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                REFRACT: begin
                    // A refractory timestep only burns one count; the potential is frozen.
                    refract_cnt_reg <= refract_cnt_reg - REFRACT_W'(1);
                    done_reg        <= 1'b1;
                    busy_reg        <= 1'b0;
                    state_reg       <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign nif.busy      = busy_reg;
    assign nif.done      = done_reg;
    assign nif.spike_out = spike_reg;
    assign nif.potential = potential_reg;

endmodule

// File: tb/tb_lif_neuron.sv
// Randomised bench for lif_neuron: a 32-bit and a 16-bit instance checked against
// an arithmetic model of timestep integration, leak, fire and refractory behaviour.
module tb_lif_neuron;

    localparam int NA = 16;

    logic clk;
    logic rst;

    lif_neuron_if #(.WIDTH(32), .WEIGHT_W(16), .NUM_AXONS(NA)) ifa ();
    lif_neuron_if #(.WIDTH(16), .WEIGHT_W(16), .NUM_AXONS(NA)) ifb ();

    logic signed [31:0] a_thr, a_leak;
    logic               a_mode;
    logic [3:0]         a_refr;
    logic signed [15:0] b_thr, b_leak;
    logic               b_mode;
    logic [3:0]         b_refr;

    lif_neuron #(.WIDTH(32), .WEIGHT_W(16), .NUM_AXONS(NA), .REFRACT_W(4)) dut (
        .clk(clk), .rst(rst), .nif(ifa.slave),
        .cfg_threshold(a_thr), .cfg_leak(a_leak),
        .cfg_reset_mode(a_mode), .cfg_refract(a_refr)
    );

    lif_neuron #(.WIDTH(16), .WEIGHT_W(16), .NUM_AXONS(NA), .REFRACT_W(4)) dut16 (
        .clk(clk), .rst(rst), .nif(ifb.slave),
        .cfg_threshold(b_thr), .cfg_leak(b_leak),
        .cfg_reset_mode(b_mode), .cfg_refract(b_refr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    longint m_w [2][NA];
    longint m_pot [2];
    int     m_refr [2];
    int     m_width [2];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint x, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic logic signed [63:0] rd_pot(input int sel);
        if (sel != 0) return 64'(ifb.potential);
        return 64'(ifa.potential);
    endfunction

    function automatic logic rd_done(input int sel);
        return (sel != 0) ? ifb.done : ifa.done;
    endfunction

    function automatic logic rd_busy(input int sel);
        return (sel != 0) ? ifb.busy : ifa.busy;
    endfunction

    function automatic logic rd_spike(input int sel);
        return (sel != 0) ? ifb.spike_out : ifa.spike_out;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_pot[s]  = 0;
            m_refr[s] = 0;
            for (int i = 0; i < NA; i++) m_w[s][i] = 0;
        end
    endtask

    task automatic drive_cfg(input int sel, input longint thr, input longint leak,
                             input bit mode, input int refr, input logic [NA-1:0] spikes);
        if (sel != 0) begin
            b_thr = 16'(thr); b_leak = 16'(leak); b_mode = mode; b_refr = 4'(refr);
            ifb.axon_spikes = spikes;
        end else begin
            a_thr = 32'(thr); a_leak = 32'(leak); a_mode = mode; a_refr = 4'(refr);
            ifa.axon_spikes = spikes;
        end
    endtask

    task automatic set_tick(input int sel, input logic v);
        if (sel != 0) ifb.tick = v; else ifa.tick = v;
    endtask

    task automatic set_wr(input int sel, input logic we, input int addr, input longint data);
        if (sel != 0) begin
            ifb.w_we = we; ifb.w_addr = 4'(addr); ifb.w_data = 16'(data);
        end else begin
            ifa.w_we = we; ifa.w_addr = 4'(addr); ifa.w_data = 16'(data);
        end
    endtask

    task automatic wr(input int sel, input int addr, input longint data);
        @(negedge clk);
        set_wr(sel, 1'b1, addr, data);
        @(posedge clk);
        #1;
        set_wr(sel, 1'b0, 0, 0);
        m_w[sel][addr] = data;
    endtask

    // One timestep: model first, then drive the tick, scramble inputs after acceptance,
    // and optionally fire a stray tick plus weight write while the neuron is busy.
    task automatic do_tick(input int sel, input logic [NA-1:0] spikes, input longint thr,
                           input longint leak, input bit mode, input int refr,
                           input bit interfere, input string tag);
        longint p, pre;
        int     lat, k;
        bit     spk, seen;
        logic signed [63:0] prev_pot;

        if (m_refr[sel] > 0) begin
            m_refr[sel]--;
            lat = 1; spk = 0; pre = m_pot[sel];
        end else begin
            p = m_pot[sel];
            for (int i = 0; i < NA; i++)
                if (spikes[i]) p = sat(p + m_w[sel][i], m_width[sel]);
            p = sat(p - leak, m_width[sel]);
            pre = p; lat = NA + 2; spk = 0;
            if (p >= thr) begin
                spk = 1;
                m_refr[sel] = refr;
                p = mode ? sat(p - thr, m_width[sel]) : 0;
            end
            m_pot[sel] = p;
        end

        @(negedge clk);
        drive_cfg(sel, thr, leak, mode, refr, spikes);
        set_tick(sel, 1'b1);
        @(posedge clk);
        #1;
        set_tick(sel, 1'b0);
        drive_cfg(sel, longint'($urandom_range(30000, 0)) - 15000,
                  longint'($urandom_range(30000, 0)) - 15000,
                  1'($urandom_range(1, 0)), $urandom_range(15, 0), 16'($urandom));
        check({tag, " busy_after_accept"}, 64'(rd_busy(sel)), 1);

        k = 0; seen = 0; prev_pot = rd_pot(sel);
        while (!seen && k < 64) begin
            prev_pot = rd_pot(sel);
            @(posedge clk);
            #1;
            k++;
            if (interfere && k == 3) begin
                set_tick(sel, 1'b1);
                set_wr(sel, 1'b1, 0, 99);
            end
            if (interfere && k == 4) begin
                set_tick(sel, 1'b0);
                set_wr(sel, 1'b0, 0, 0);
            end
            seen = rd_done(sel);
        end

        check({tag, " latency"}, 64'(k), 64'(lat));
        check({tag, " spike_out"}, 64'(rd_spike(sel)), 64'(spk));
        check({tag, " potential"}, rd_pot(sel), m_pot[sel]);
        check({tag, " pre_fire_potential"}, prev_pot, pre);
        check({tag, " busy_at_done"}, 64'(rd_busy(sel)), 0);
        @(posedge clk);
        #1;
        check({tag, " done_pulse_end"}, 64'(rd_done(sel)), 0);
        check({tag, " idle_after"}, 64'(rd_busy(sel)), 0);
        $display("tick %-16s dut=%0d lat=%0d spike=%0d pot=%0d exp_pot=%0d",
                 tag, sel, k, rd_spike(sel), rd_pot(sel), m_pot[sel]);
    endtask

    initial begin
        int ndone;
        m_width[0] = 32;
        m_width[1] = 16;
        model_reset();
        rst = 1'b0;
        set_tick(0, 1'b0); set_tick(1, 1'b0);
        set_wr(0, 1'b0, 0, 0); set_wr(1, 1'b0, 0, 0);
        drive_cfg(0, 0, 0, 0, 0, '0);
        drive_cfg(1, 0, 0, 0, 0, '0);

        repeat (2) @(posedge clk);
        #1;
        check("reset potential", rd_pot(0), 0);
        check("reset busy", 64'(rd_busy(0)), 0);
        check("reset done", 64'(rd_done(0)), 0);
        check("reset spike", 64'(rd_spike(0)), 0);
        @(negedge clk);
        rst = 1'b1;

        // Abort a timestep half way through integration.
        wr(0, 0, 50);
        @(negedge clk);
        drive_cfg(0, 100, 0, 0, 0, 16'hFFFF);
        set_tick(0, 1'b1);
        @(posedge clk);
        #1;
        set_tick(0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("midrun busy", 64'(rd_busy(0)), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort potential", rd_pot(0), 0);
        check("abort busy", 64'(rd_busy(0)), 0);
        check("abort done", 64'(rd_done(0)), 0);
        check("abort spike", 64'(rd_spike(0)), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        ndone = 0;
        repeat (24) begin
            @(posedge clk);
            #1;
            if (rd_done(0)) ndone++;
        end
        check("abort no_done", 64'(ndone), 0);
        do_tick(0, 16'hFFFF, 100, 0, 0, 0, 0, "post_reset");

        // Integrate without firing, then fire in subtract mode.
        wr(0, 0, 10);
        wr(0, 3, 20);
        do_tick(0, 16'h0009, 100, 5, 0, 0, 0, "integrate");
        do_tick(0, 16'h0009, 40, 5, 1, 2, 0, "fire_sub");
        do_tick(0, 16'hFFFF, 40, 5, 1, 2, 0, "refract1");
        do_tick(0, 16'hFFFF, 40, 5, 1, 2, 0, "refract2");
        do_tick(0, 16'hFFFF, 40, 5, 1, 2, 0, "after_refract");

        // Stray tick and weight write while busy must be dropped.
        do_tick(0, 16'h0001, 1000, 0, 0, 0, 1, "busy_ignore");
        do_tick(0, 16'h0001, 1000, 0, 0, 0, 0, "w0_kept");

        for (int n = 0; n < 30; n++) begin
            int nw;
            nw = $urandom_range(2, 0);
            for (int j = 0; j < nw; j++)
                wr(0, $urandom_range(NA - 1, 0), longint'($urandom_range(4000, 0)) - 2000);
            do_tick(0, 16'($urandom), longint'($urandom_range(3000, 0)) - 500,
                    longint'($urandom_range(150, 0)) - 30, 1'($urandom_range(1, 0)),
                    $urandom_range(3, 0), 0, "rand");
        end

        // Saturation at both rails on the 16-bit instance.
        for (int i = 0; i < NA; i++) wr(1, i, -32768);
        do_tick(1, 16'hFFFF, 0, 0, 0, 0, 0, "sat_neg");
        for (int i = 0; i < NA; i++) wr(1, i, 32767);
        do_tick(1, 16'hFFFF, 32767, 0, 0, 0, 0, "sat_pos");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
